// File: rtl/int_acceptor.sv
// CPU-side interrupt acceptor: INTE/EI-delay handling, request latch, and
// acknowledge/inject handshake toward the fetch stage.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no request held; a new request is taken only while INTE=1
// PENDING | request latched, waiting for an instruction boundary or HLT
// ACK     | INTA raised, latched instruction offered to fetch
module int_acceptor #(
  parameter int INSTR_W = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               interrupt,
  input  logic [INSTR_W-1:0] interrupt_instruction,
  input  logic               ei,
  input  logic               di,
  input  logic               instr_done,
  input  logic               halted,
  input  logic               inject_taken,
  output logic               inte,
  output logic               int_pending,
  output logic               inta,
  output logic               inject_valid,
  output logic [INSTR_W-1:0] inject_instruction
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ACK     = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 inte_q, inte_d;
  logic                 ei_armed_q, ei_armed_d;
  logic                 pending_q, ack_q;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 dispatch;

  always_comb begin
    state_d    = state_q;
    inte_d     = inte_q;
    ei_armed_d = ei_armed_q;
    instr_d    = instr_q;
    dispatch   = 1'b0;

    case (state_q)
      IDLE: begin
        if (interrupt && inte_q) begin
          state_d = PENDING;
          instr_d = interrupt_instruction;
        end
      end
      PENDING: begin
        if (di) begin
          state_d = IDLE;
        end else if (instr_done || halted) begin
          state_d  = ACK;
          dispatch = 1'b1;
        end
      end
      ACK: begin
        if (inject_taken) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Accepting an interrupt behaves like an implicit DI; an EI retiring at
    // a boundary with EI already armed (EI;EI) enables and re-arms.
    if (di || dispatch) begin
      inte_d     = 1'b0;
      ei_armed_d = 1'b0;
    end else begin
      if (instr_done && ei_armed_q) inte_d = 1'b1;
      ei_armed_d = ei || (ei_armed_q && !instr_done);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      inte_q     <= 1'b0;
      ei_armed_q <= 1'b0;
      pending_q  <= 1'b0;
      ack_q      <= 1'b0;
      instr_q    <= '0;
    end else begin
      state_q    <= state_d;
      inte_q     <= inte_d;
      ei_armed_q <= ei_armed_d;
      pending_q  <= (state_d == PENDING);
      ack_q      <= (state_d == ACK);
      instr_q    <= instr_d;
    end
  end

  assign inte               = inte_q;
  assign int_pending        = pending_q;
  assign inta               = ack_q;
  assign inject_valid       = ack_q;
  assign inject_instruction = instr_q;

endmodule

// File: tb/tb_int_acceptor.sv
// Self-checking bench for int_acceptor: directed timelines plus a random run
// checked against a request/acknowledge reference model.
module tb_int_acceptor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        interrupt = 1'b0;
  logic [23:0] interrupt_instruction = '0;
  logic        ei = 1'b0;
  logic        di = 1'b0;
  logic        instr_done = 1'b0;
  logic        halted = 1'b0;
  logic        inject_taken = 1'b0;
  logic        inte, int_pending, inta, inject_valid;
  logic [23:0] inject_instruction;

  int n_assert = 0;
  int n_fail   = 0;

  int_acceptor #(.INSTR_W(24)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .interrupt             (interrupt),
    .interrupt_instruction (interrupt_instruction),
    .ei                    (ei),
    .di                    (di),
    .instr_done            (instr_done),
    .halted                (halted),
    .inject_taken          (inject_taken),
    .inte                  (inte),
    .int_pending           (int_pending),
    .inta                  (inta),
    .inject_valid          (inject_valid),
    .inject_instruction    (inject_instruction)
  );

  always #5 clk = ~clk;

  // Drive one cycle of pulses, let the edge happen, then return 1 time unit
  // after it with pulses cleared; outputs then reflect the following cycle.
  task automatic cyc(input logic e, input logic d, input logic dn,
                     input logic irq, input logic [23:0] ins, input logic tk);
    ei = e; di = d; instr_done = dn; interrupt = irq;
    interrupt_instruction = ins; inject_taken = tk;
    @(posedge clk); #1;
    ei = 0; di = 0; instr_done = 0; interrupt = 0; inject_taken = 0;
  endtask

  task automatic do_reset();
    halted = 0;
    reset_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_assert++;
    if ({inte, int_pending, inta, inject_valid} !== 4'b0000 || inject_instruction !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got inte=%b pend=%b inta=%b iv=%b instr=%h, want all 0",
               inte, int_pending, inta, inject_valid, inject_instruction);
    end
  endtask

  task automatic test_drop_when_disabled();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      cyc(0, 0, (c == 15), (c == 12), 24'hFF0000, 0);
      n_assert++;
      if (int_pending !== 1'b0 || inject_valid !== 1'b0 || inte !== 1'b0) begin
        n_fail++;
        $display("FAIL disabled_drop c=%0d: got pend=%b iv=%b inte=%b, want 0 0 0",
                 c, int_pending, inject_valid, inte);
      end
    end
  endtask

  task automatic test_ei_dispatch();
    logic exp_inte, exp_pend, exp_ack;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      cyc((c == 2), 0, (c == 2 || c == 5 || c == 15), (c == 12), 24'hFF0000, (c == 18));
      exp_inte = (c >= 5 && c < 15);
      exp_pend = (c >= 12 && c < 15);
      exp_ack  = (c >= 15 && c < 18);
      n_assert++;
      if (inte !== exp_inte || int_pending !== exp_pend || inta !== exp_ack || inject_valid !== exp_ack) begin
        n_fail++;
        $display("FAIL ei_dispatch cycle %0d: got inte=%b pend=%b inta=%b iv=%b, want %b %b %b %b",
                 c + 1, inte, int_pending, inta, inject_valid, exp_inte, exp_pend, exp_ack, exp_ack);
      end
      if (c >= 12) begin
        n_assert++;
        if (inject_instruction !== 24'hFF0000) begin
          n_fail++;
          $display("FAIL ei_dispatch_instr cycle %0d: got %h, want ff0000", c + 1, inject_instruction);
        end
      end
    end
  endtask

  task automatic test_di_cancel();
    do_reset();
    cyc(1, 0, 1, 0, 24'h0, 0);
    cyc(0, 0, 1, 0, 24'h0, 0);
    cyc(0, 0, 0, 1, 24'hC70000, 0);
    n_assert++;
    if (int_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL di_cancel_latch: got pend=%b, want 1", int_pending);
    end
    cyc(0, 1, 1, 0, 24'h0, 0);
    n_assert++;
    if (int_pending !== 1'b0 || inta !== 1'b0 || inject_valid !== 1'b0 || inte !== 1'b0) begin
      n_fail++;
      $display("FAIL di_cancel: got pend=%b inta=%b iv=%b inte=%b, want 0 0 0 0",
               int_pending, inta, inject_valid, inte);
    end
    cyc(0, 0, 1, 0, 24'h0, 0);
    n_assert++;
    if (inta !== 1'b0) begin
      n_fail++;
      $display("FAIL di_cancel_noack: got inta=%b, want 0", inta);
    end
  endtask

  task automatic test_halted();
    do_reset();
    cyc(1, 0, 1, 0, 24'h0, 0);
    cyc(0, 0, 1, 0, 24'h0, 0);
    halted = 1;
    cyc(0, 0, 0, 1, 24'hD70000, 0);
    n_assert++;
    if (int_pending !== 1'b1 || inta !== 1'b0) begin
      n_fail++;
      $display("FAIL halted_t1: got pend=%b inta=%b, want 1 0", int_pending, inta);
    end
    cyc(0, 0, 0, 0, 24'h0, 0);
    n_assert++;
    if (inta !== 1'b1 || inject_valid !== 1'b1 || inte !== 1'b0 || inject_instruction !== 24'hD70000) begin
      n_fail++;
      $display("FAIL halted_t2: got inta=%b iv=%b inte=%b instr=%h, want 1 1 0 d70000",
               inta, inject_valid, inte, inject_instruction);
    end
    halted = 0;
  endtask

  task automatic test_ei_window_drop();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      cyc((c == 2), 0, (c == 2 || c == 6), (c == 3), 24'hCF0000, 0);
      n_assert++;
      if (int_pending !== 1'b0 || inte !== (c >= 6)) begin
        n_fail++;
        $display("FAIL ei_window cycle %0d: got pend=%b inte=%b, want 0 %b",
                 c + 1, int_pending, inte, (c >= 6));
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(1, 0, 1, 0, 24'h0, 0);
    cyc(0, 0, 1, 0, 24'h0, 0);
    cyc(0, 0, 0, 1, 24'hEF0000, 0);
    cyc(0, 0, 1, 0, 24'h0, 0);
    n_assert++;
    if (inta !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre_ack: got inta=%b, want 1", inta);
    end
    #2 reset_n = 0;
    #1;
    n_assert++;
    if ({inte, int_pending, inta, inject_valid} !== 4'b0000 || inject_instruction !== 24'h0) begin
      n_fail++;
      $display("FAIL async_reset: got inte=%b pend=%b inta=%b iv=%b instr=%h, want all 0",
               inte, int_pending, inta, inject_valid, inject_instruction);
    end
    @(negedge clk);
    reset_n = 1;
    @(posedge clk); #1;
    cyc(0, 0, 1, 1, 24'hEF0000, 0);
    n_assert++;
    if (int_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL async_post_ignore: got pend=%b, want 0", int_pending);
    end
    cyc(1, 0, 1, 0, 24'h0, 0);
    cyc(0, 0, 1, 0, 24'h0, 0);
    cyc(0, 0, 0, 1, 24'hE70000, 0);
    n_assert++;
    if (int_pending !== 1'b1 || inject_instruction !== 24'hE70000) begin
      n_fail++;
      $display("FAIL async_post_ei: got pend=%b instr=%h, want 1 e70000", int_pending, inject_instruction);
    end
  endtask

  // Reference model: a held request is either waiting for a boundary or being
  // offered to fetch; INTE follows EI (delayed one boundary) / DI / acceptance.
  task automatic test_random();
    logic m_inte, m_armed, m_waiting, m_offered;
    logic [23:0] m_instr;
    logic r_ei, r_di, r_done, r_irq, r_tk;
    logic [23:0] r_ins;
    logic accept, dispatch;
    do_reset();
    m_inte = 0; m_armed = 0; m_waiting = 0; m_offered = 0; m_instr = '0;
    for (int c = 0; c < 600; c++) begin
      r_done = ($urandom_range(2) == 0);
      r_ei   = r_done && ($urandom_range(2) == 0);
      r_di   = ($urandom_range(11) == 0);
      r_irq  = ($urandom_range(3) == 0);
      r_tk   = ($urandom_range(1) == 0);
      r_ins  = 24'($urandom);
      if ($urandom_range(9) == 0) halted = ~halted;

      accept   = !m_waiting && !m_offered && r_irq && m_inte;
      dispatch = m_waiting && (r_done || halted) && !r_di;
      if (accept) m_instr = r_ins;
      if (m_offered && r_tk) m_offered = 0;
      if (m_waiting && (r_di || dispatch)) m_waiting = 0;
      if (dispatch) m_offered = 1;
      if (accept) m_waiting = 1;
      if (r_di || dispatch) begin
        m_inte = 0; m_armed = 0;
      end else begin
        if (r_done && m_armed) m_inte = 1;
        m_armed = r_ei || (m_armed && !r_done);
      end

      cyc(r_ei, r_di, r_done, r_irq, r_ins, r_tk);
      n_assert++;
      if (inte !== m_inte || int_pending !== m_waiting || inta !== m_offered ||
          inject_valid !== m_offered || inject_instruction !== m_instr) begin
        n_fail++;
        $display("FAIL random step %0d: got inte=%b pend=%b inta=%b iv=%b instr=%h, want %b %b %b %b %h",
                 c, inte, int_pending, inta, inject_valid, inject_instruction,
                 m_inte, m_waiting, m_offered, m_offered, m_instr);
      end
    end
    halted = 0;
  endtask

  initial begin
    test_reset();
    test_drop_when_disabled();
    test_ei_dispatch();
    test_di_cancel();
    test_halted();
    test_ei_window_drop();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
